// File: rtl/button_arbiter.sv
// Synchronises and debounces the seven game buttons, builds press and auto-repeat events,
// and issues queued events one at a time over a valid/ready handshake.
module button_arbiter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       up_button,
    input  logic       down_button,
    input  logic       left_button,
    input  logic       right_button,
    input  logic       a_button,
    input  logic       b_button,
    input  logic       start_button,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       cmd_repeat,
    output logic [6:0] btn_state,
    output logic       overrun
);

    localparam int NB = 7;
    localparam int NR = 4;
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync_1;
    logic [NB-1:0]    raw_s;
    logic [CNT_W-1:0] db_cnt [NB];
    logic [NB-1:0]    btn_prev;
    logic [NB-1:0]    press_evt;
    logic [NB-1:0]    fall_evt;
    logic [CNT_W-1:0] rep_tmr [NR];
    logic [NR-1:0]    rep_run;
    logic [NR-1:0]    rep_first;
    logic [NR-1:0]    rep_fire;
    logic [NB-1:0]    rep_evt;
    logic [NB-1:0]    pend;
    logic [NB-1:0]    pend_rep;
    logic [NB-1:0]    grant;
    logic             any_pend;
    logic             slot_free;
    logic [2:0]       sel_code;

    assign raw = {start_button, b_button, a_button, right_button,
                  left_button, down_button, up_button};

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync_1 <= '0;
            raw_s  <= '0;
        end else begin
            sync_1 <= raw;
            raw_s  <= sync_1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
            btn_state <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (raw_s[i] == btn_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]    <= '0;
                    btn_state[i] <= raw_s[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            btn_prev  <= '0;
            press_evt <= '0;
            fall_evt  <= '0;
        end else begin
            btn_prev  <= btn_state;
            press_evt <= btn_state & ~btn_prev;
            fall_evt  <= ~btn_state & btn_prev;
        end
    end

    // Repeat timer restarts at each press; the first interval is the long delay, then the rate.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) rep_tmr[i] <= '0;
            rep_run   <= '0;
            rep_first <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (press_evt[i]) begin
                    rep_run[i]   <= 1'b1;
                    rep_first[i] <= 1'b1;
                    rep_tmr[i]   <= '0;
                end else if (!btn_state[i]) begin
                    rep_run[i] <= 1'b0;
                    rep_tmr[i] <= '0;
                end else if (rep_fire[i]) begin
                    rep_first[i] <= 1'b0;
                    rep_tmr[i]   <= '0;
                end else if (rep_run[i]) begin
                    rep_tmr[i] <= rep_tmr[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NR; i++) begin
            rep_fire[i] = rep_run[i] && btn_state[i] &&
                          (rep_tmr[i] == (rep_first[i] ? DELAY_LAST : RATE_LAST));
        end
    end

    assign rep_evt = {{(NB-NR){1'b0}}, rep_fire};

    // Fixed priority: start > b > a > up > down > left > right.
    always_comb begin
        sel_code  = 3'd0;
        any_pend  = 1'b1;
        grant     = '0;
        slot_free = !cmd_valid || cmd_ready;
        if      (pend[6]) sel_code = 3'd6;
        else if (pend[5]) sel_code = 3'd5;
        else if (pend[4]) sel_code = 3'd4;
        else if (pend[0]) sel_code = 3'd0;
        else if (pend[1]) sel_code = 3'd1;
        else if (pend[2]) sel_code = 3'd2;
        else if (pend[3]) sel_code = 3'd3;
        else              any_pend = 1'b0;
        if (slot_free && any_pend) grant[sel_code] = 1'b1;
    end

    // A new event beats a same-cycle grant; merging into a still-pending event flags overrun.
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            pend       <= '0;
            pend_rep   <= '0;
            overrun    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 3'd0;
            cmd_repeat <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (press_evt[i]) begin
                    pend[i]     <= 1'b1;
                    pend_rep[i] <= 1'b0;
                    if (pend[i] && !grant[i]) overrun <= 1'b1;
                end else if (rep_evt[i]) begin
                    if (pend[i] && !grant[i]) begin
                        overrun <= 1'b1;
                    end else begin
                        pend[i]     <= 1'b1;
                        pend_rep[i] <= 1'b1;
                    end
                end else if (grant[i] || (fall_evt[i] && pend_rep[i])) begin
                    pend[i] <= 1'b0;
                end
            end
            if (slot_free) begin
                cmd_valid <= any_pend;
                if (any_pend) begin
                    cmd_code   <= sel_code;
                    cmd_repeat <= pend_rep[sel_code];
                end
            end
        end
    end

endmodule

// File: tb/tb_button_arbiter.sv
// Directed bench for button_arbiter: expected commands are queued as buttons are driven
// and compared against every accepted handshake.
`timescale 1ns/1ps
module tb_button_arbiter;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk_50MHz    = 1'b0;
    logic       reset        = 1'b0;
    logic       up_button    = 1'b0;
    logic       down_button  = 1'b0;
    logic       left_button  = 1'b0;
    logic       right_button = 1'b0;
    logic       a_button     = 1'b0;
    logic       b_button     = 1'b0;
    logic       start_button = 1'b0;
    logic       cmd_ready    = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_repeat;
    logic [6:0] btn_state;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] code;
        logic       rep;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    button_arbiter #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .CNT_W(8)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .reset(reset),
        .up_button(up_button),
        .down_button(down_button),
        .left_button(left_button),
        .right_button(right_button),
        .a_button(a_button),
        .b_button(b_button),
        .start_button(start_button),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .cmd_repeat(cmd_repeat),
        .btn_state(btn_state),
        .overrun(overrun)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic push_exp(input logic [2:0] code, input logic rep, input int at);
        exp_q.push_back('{code, rep, at});
    endtask

    // Every accepted command must match the oldest expectation (code, repeat flag, cycle).
    always @(negedge clk_50MHz) begin
        if (reset && cmd_valid && cmd_ready) begin
            check_output("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_output("cmd_code", 32'(cmd_code), 32'(mon_e.code));
                check_output("cmd_repeat", 32'(cmd_repeat), 32'(mon_e.rep));
                if (mon_e.at >= 0) check_output("cmd_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    initial begin
        int   t0;
        logic seen;

        reset = 1'b0;
        step(2);
        check_output("rst_valid", 32'(cmd_valid), 32'd0);
        check_output("rst_code", 32'(cmd_code), 32'd0);
        check_output("rst_repeat", 32'(cmd_repeat), 32'd0);
        check_output("rst_btn_state", 32'(btn_state), 32'd0);
        check_output("rst_overrun", 32'(overrun), 32'd0);
        reset     = 1'b1;
        cmd_ready = 1'b1;
        step(2);

        // Held up: press command, then repeats 20 and every 8 cycles after it.
        $display("[TB] hold up with auto-repeat");
        t0 = cyc + 1;
        up_button = 1'b1;
        push_exp(3'd0, 1'b0, t0 + 8);
        push_exp(3'd0, 1'b1, t0 + 28);
        push_exp(3'd0, 1'b1, t0 + 36);
        push_exp(3'd0, 1'b1, t0 + 44);
        wait_until(t0 + 20);
        check_output("t1_btn_up", 32'(btn_state[0]), 32'd1);
        wait_until(t0 + 39);
        up_button = 1'b0;
        wait_until(t0 + 60);
        check_output("t1_drained", 32'(exp_q.size()), 32'd0);
        check_output("t1_btn_up_low", 32'(btn_state[0]), 32'd0);

        // Short glitch on a must never be accepted.
        $display("[TB] 3-cycle glitch on a");
        seen = 1'b0;
        a_button = 1'b1;
        step(3);
        a_button = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            seen = seen | btn_state[4] | cmd_valid;
        end
        check_output("t2_glitch_seen", 32'(seen), 32'd0);

        // Simultaneous presses drain in priority order on consecutive cycles.
        $display("[TB] simultaneous start, a, left");
        t0 = cyc + 1;
        start_button = 1'b1;
        a_button     = 1'b1;
        left_button  = 1'b1;
        push_exp(3'd6, 1'b0, t0 + 8);
        push_exp(3'd4, 1'b0, t0 + 9);
        push_exp(3'd2, 1'b0, t0 + 10);
        step(10);
        start_button = 1'b0;
        a_button     = 1'b0;
        left_button  = 1'b0;
        wait_until(t0 + 30);
        check_output("t3_drained", 32'(exp_q.size()), 32'd0);
        check_output("t3_overrun", 32'(overrun), 32'd0);

        // Stalled consumer: repeated b presses hold the output and merge into one pending.
        $display("[TB] stalled consumer with repeated b presses");
        cmd_ready = 1'b0;
        t0 = cyc + 1;
        b_button = 1'b1;
        step(10);
        b_button = 1'b0;
        wait_until(t0 + 12);
        check_output("t4_valid_held", 32'(cmd_valid), 32'd1);
        check_output("t4_code_held", 32'(cmd_code), 32'd5);
        wait_until(t0 + 19);
        b_button = 1'b1;
        step(10);
        b_button = 1'b0;
        step(6);
        check_output("t4_overrun_second", 32'(overrun), 32'd0);
        step(4);
        b_button = 1'b1;
        step(10);
        b_button = 1'b0;
        step(10);
        check_output("t4_valid_still", 32'(cmd_valid), 32'd1);
        check_output("t4_code_still", 32'(cmd_code), 32'd5);
        check_output("t4_repeat_still", 32'(cmd_repeat), 32'd0);
        check_output("t4_overrun_third", 32'(overrun), 32'd1);
        push_exp(3'd5, 1'b0, -1);
        push_exp(3'd5, 1'b0, -1);
        cmd_ready = 1'b1;
        step(10);
        check_output("t4_drained", 32'(exp_q.size()), 32'd0);
        check_output("t4_idle", 32'(cmd_valid), 32'd0);

        // A pending repeat is dropped when right is released before it is accepted.
        $display("[TB] right held past repeat under stall, then released");
        cmd_ready = 1'b0;
        t0 = cyc + 1;
        right_button = 1'b1;
        step(32);
        right_button = 1'b0;
        wait_until(t0 + 45);
        check_output("t5_valid_held", 32'(cmd_valid), 32'd1);
        check_output("t5_code_held", 32'(cmd_code), 32'd3);
        check_output("t5_repeat_held", 32'(cmd_repeat), 32'd0);
        push_exp(3'd3, 1'b0, -1);
        cmd_ready = 1'b1;
        step(10);
        check_output("t5_drained", 32'(exp_q.size()), 32'd0);
        check_output("t5_idle", 32'(cmd_valid), 32'd0);

        // Reset with a command waiting and another pending discards both.
        $display("[TB] reset mid-operation");
        cmd_ready = 1'b0;
        t0 = cyc + 1;
        start_button = 1'b1;
        b_button     = 1'b1;
        wait_until(t0 + 12);
        check_output("t6_valid_before", 32'(cmd_valid), 32'd1);
        check_output("t6_code_before", 32'(cmd_code), 32'd6);
        reset = 1'b0;
        #1;
        check_output("t6_rst_valid", 32'(cmd_valid), 32'd0);
        check_output("t6_rst_code", 32'(cmd_code), 32'd0);
        check_output("t6_rst_repeat", 32'(cmd_repeat), 32'd0);
        check_output("t6_rst_btn_state", 32'(btn_state), 32'd0);
        check_output("t6_rst_overrun", 32'(overrun), 32'd0);
        start_button = 1'b0;
        b_button     = 1'b0;
        cmd_ready    = 1'b1;
        step(3);
        reset = 1'b1;
        step(20);
        check_output("t6_no_cmd", 32'(cmd_valid), 32'd0);
        check_output("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
